branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Program-counter sequencer for picoNISC. It fetches control words from instruction memory with a req/ack handshake.
- It samples the 1-bit branch comparator result (`cmp_result`, high when a==b) in the execute state and decides whether the next PC is PC+1 or the branch target.
- It raises a one-cycle flush on taken branches and stops on halt.
- It sits between instruction memory, the control-word decode and the branch comparator.

Parameters:
- PC_W, 8, width of PC, fetch address and branch target.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, held until acknowledged.
- imem_addr  output  PC_W  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  instruction memory has presented the control word.
- cw_valid  input  1  decoded control word fields below are valid this cycle.
- br_en  input  1  control word is a conditional branch.
- br_ne  input  1  0 = branch if equal, 1 = branch if not equal.
- br_target  input  PC_W  branch destination.
- halt  input  1  control word is a halt.
- cmp_result  input  1  branch comparator output.
- pc  output  PC_W  current program counter.
- flush  output  1  one-cycle pulse on a taken branch.
- halted  output  1  high while in HALT.

Behaviour:
- Reset: n_reset low forces the following immediately, independent of clk:
  - state=IDLE
  - pc=RESET_PC
  - imem_req=0
  - flush=0
  - halted=0
- Reset mid-operation: any state and any outstanding request is abandoned.
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered.
- IDLE:
  - Entered only from reset.
  - Next edge goes to FETCH with imem_req=1.
  - The first request is therefore visible 1 cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack=1 at an edge: go to EXEC and drop imem_req in the same edge.
  - imem_ack=0: hold, with req and addr stable.
- EXEC:
  - cw_valid=0: stall in EXEC; pc unchanged.
  - cw_valid=1 and halt=1: go to HALT, halted=1, pc unchanged. halt has priority over br_en.
  - cw_valid=1 otherwise: take = br_en & (cmp_result ^ br_ne).
  - take=1: pc<=br_target, flush=1 for exactly that one cycle, go to FETCH with imem_req=1.
  - take=0: pc<=pc+1 modulo 2^PC_W (wraps to 0 from all-ones, no error), flush=0, go to FETCH.
- HALT:
  - Terminal state; all inputs ignored.
  - imem_req=0, halted=1.
  - Exits only via reset.
- Latency:
  - Minimum 2 cycles per control word (FETCH with same-cycle ack, then EXEC).
  - Each wait cycle on ack or cw_valid adds 1 cycle.
- flush:
  - Never asserted outside the cycle following a taken-branch EXEC edge.
  - Back-to-back taken branches give separate pulses, at least 2 cycles apart.
- Input sampling:
  - imem_ack in IDLE, EXEC and HALT is ignored.
  - cmp_result is sampled only on the EXEC edge with cw_valid=1.

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- Defined:
  - Adds output taken_cnt (16 bits) and output retired_cnt (16 bits).
  - Both reset to 0 and wrap silently.
  - retired_cnt increments on every EXEC edge with cw_valid=1 and halt=0.
  - taken_cnt increments when take=1.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset then sequential fetch: release n_reset, ack every request, feed br_en=0.
  - imem_req first high 1 cycle after release.
  - imem_addr sequence 0,1,2,3.
  - 2 cycles per word, flush never high.
- Taken BEQ: pc=5, br_en=1, br_ne=0, cmp_result=1, br_target=0x40.
  - Next pc=0x40.
  - flush high exactly 1 cycle.
  - Next imem_addr=0x40.
- Not-taken and BNE: pc=5, br_en=1, br_ne=0, cmp_result=0 → pc=6, no flush.
  - Then br_ne=1, cmp_result=0, br_target=0x10 → pc=0x10 with flush.
- Stalls and wrap: hold imem_ack=0 for 3 cycles at pc=0xFF.
  - imem_req and addr 0xFF stable throughout.
  - Then hold cw_valid=0 for 2 cycles in EXEC.
  - Then br_en=0 → pc=0x00.
- Halt priority: halt=1 with br_en=1 and a taken condition.
  - halted=1, pc unchanged, no flush.
  - imem_req stays 0 for 10 cycles despite imem_ack=1.
- Async reset mid-fetch: assert n_reset low between edges while imem_req=1 and pc=0x22.
  - pc=RESET_PC and imem_req=0 before the next clk edge.
  - With BRANCH_CTRL_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Program-counter sequencer: fetches control words over a req/ack handshake and resolves conditional branches.
// Optional BRANCH_CTRL_STATS_EN adds retired/taken instruction counters.
//
// state | meaning
// IDLE  | just out of reset, first fetch issued on the next edge
// FETCH | imem_req held at pc until imem_ack
// EXEC  | waiting for a valid control word; resolves branch or halt
// HALT  | terminal, left only by reset
module branch_ctrl #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            n_reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            cw_valid,
  input  logic            br_en,
  input  logic            br_ne,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt,
  input  logic            cmp_result,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            halted
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     retired_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            take, retire;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    flush_d  = 1'b0;
    halted_d = halted_q;
    take     = 1'b0;
    retire   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = EXEC;
          req_d   = 1'b0;
        end
      end
      EXEC: begin
        if (cw_valid) begin
          if (halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
            req_d    = 1'b0;
          end else begin
            // br_ne inverts the sense of the equality result
            take    = br_en & (cmp_result ^ br_ne);
            retire  = 1'b1;
            pc_d    = take ? br_target : pc_q + PC_W'(1);
            flush_d = take;
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end
      end
      HALT: begin
        req_d    = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flush     = flush_q;
  assign halted    = halted_q;

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      taken_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 16'd1;
      if (take)   taken_cnt   <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver plays imem + decoder and queues each expected fetch;
// a monitor pops and checks every new request (address, flush, cycle gap).
module tb_branch_ctrl;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic            cw_valid = 1'b0;
  logic            br_en = 1'b0;
  logic            br_ne = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic            halt = 1'b0;
  logic            cmp_result = 1'b0;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic            halted;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0]     taken_cnt, retired_cnt;
  int              m_taken = 0, m_retired = 0;
`endif

  branch_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .n_reset(n_reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .cw_valid(cw_valid), .br_en(br_en), .br_ne(br_ne),
    .br_target(br_target), .halt(halt), .cmp_result(cmp_result),
    .pc(pc), .flush(flush), .halted(halted)
`ifdef BRANCH_CTRL_STATS_EN
    , .taken_cnt(taken_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int fl;
    int gap;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mpc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic junk();
    br_en      = 1'($urandom);
    br_ne      = 1'($urandom);
    cmp_result = 1'($urandom);
    halt       = 1'($urandom);
    br_target  = PC_W'($urandom);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    errors++;
    checks++;
    $display("FAIL req_timeout: imem_req never rose at %0t", $time);
    finish_run();
  endtask

  task automatic do_word(input bit be, input bit ne, input bit cmp, input bit h,
                         input int tgt, input int aw, input int cw);
    bit   taken;
    exp_t e;
    wait_req();
    repeat (aw) begin
      imem_ack = 1'b0;
      @(negedge clk);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (cw) begin
      cw_valid = 1'b0;
      junk();
      @(negedge clk);
    end
    if (!h) begin
      taken = be && (ne ? !cmp : cmp);
      mpc   = taken ? tgt : (mpc + 1) % 256;
      e.addr = mpc;
      e.fl   = taken;
      e.gap  = aw + cw + 2;
      q.push_back(e);
`ifdef BRANCH_CTRL_STATS_EN
      m_retired++;
      if (taken) m_taken++;
`endif
    end
    cw_valid   = 1'b1;
    br_en      = be;
    br_ne      = ne;
    cmp_result = cmp;
    halt       = h;
    br_target  = PC_W'(tgt);
    @(negedge clk);
    cw_valid = 1'b0;
    junk();
  endtask

  task automatic push_reset_fetch();
    exp_t e;
    q.delete();
    mpc    = 0;
    e.addr = 0;
    e.fl   = 0;
    e.gap  = 1;
    q.push_back(e);
`ifdef BRANCH_CTRL_STATS_EN
    m_taken   = 0;
    m_retired = 0;
`endif
  endtask

  // monitor
  initial begin
    int   cyc = 0;
    logic prev_req = 1'b0;
    int   prev_addr = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!n_reset) begin
        cyc = 0;
        prev_req = 1'b0;
        continue;
      end
      cyc++;
      if (imem_req && !prev_req) begin
        if (q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = q.pop_front();
          chk("fetch_addr", int'(imem_addr), e.addr);
          chk("pc", int'(pc), e.addr);
          chk("flush", int'(flush), e.fl);
          chk("word_cycles", cyc, e.gap);
        end
        cyc = 0;
      end else begin
        if (flush) chk("stray_flush", 1, 0);
        if (imem_req && prev_req) chk("req_addr_stable", int'(imem_addr), prev_addr);
      end
      prev_req  = imem_req;
      prev_addr = int'(imem_addr);
    end
  end

  initial begin
    push_reset_fetch();
    repeat (3) @(negedge clk);
    chk("rst_req", int'(imem_req), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    n_reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_word(0, 0, 1'($urandom), 0, $urandom_range(0, 255), 0, 0);
    do_word(1, 0, 1, 0, 8'h40, 0, 0);   // taken BEQ at 5
    do_word(1, 1, 0, 0, 8'h05, 0, 0);   // taken BNE back to 5
    do_word(1, 0, 0, 0, 8'h33, 0, 0);   // BEQ not taken -> 6
    do_word(1, 1, 0, 0, 8'h10, 0, 0);   // BNE taken -> 0x10
    do_word(1, 0, 1, 0, 8'hFF, 1, 0);   // -> 0xFF
    do_word(0, 0, 0, 0, 8'h77, 3, 2);   // stalls, wrap to 0

    for (int i = 0; i < 150; i++)
      do_word(1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom_range(0, 255),
              $urandom_range(0, 2), $urandom_range(0, 2));

    do_word(1, 0, 1, 0, 8'h22, 0, 1);
    wait_req();
    chk("pre_reset_pc", int'(pc), 8'h22);
    chk("pre_reset_q_empty", q.size(), 0);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_req", int'(imem_req), 0);
    chk("async_rst_flush", int'(flush), 0);
    chk("async_rst_halted", int'(halted), 0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("async_rst_taken_cnt", int'(taken_cnt), 0);
    chk("async_rst_retired_cnt", int'(retired_cnt), 0);
`endif
    push_reset_fetch();
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_word(1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom_range(0, 255),
              $urandom_range(0, 1), $urandom_range(0, 1));
    wait_req();
`ifdef BRANCH_CTRL_STATS_EN
    chk("taken_cnt", int'(taken_cnt), m_taken);
    chk("retired_cnt", int'(retired_cnt), m_retired);
`endif
    do_word(1, 0, 1, 1, 8'h99, 0, 1);   // halt wins over a taken branch
    chk("halt_halted", int'(halted), 1);
    chk("halt_pc", int'(pc), mpc);
    chk("halt_flush", int'(flush), 0);
    chk("halt_req", int'(imem_req), 0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      chk("halt_req_hold", int'(imem_req), 0);
      chk("halt_stays", int'(halted), 1);
    end
    imem_ack = 1'b0;
    chk("queue_drained", q.size(), 0);
    finish_run();
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
